// File: rtl/alu_out_serializer.sv
// Serializes ALU result words onto a one-bit line: start, data LSB first, optional parity, stop.
// Define ALU_SER_PARITY_EN to insert an even-parity bit after the data bits.
module alu_out_serializer #(
  parameter int unsigned IN_DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_VALID,
  output logic                     TX_OUT,
  output logic                     TX_BUSY,
  output logic                     OVERRUN
);

  localparam int unsigned CntW = (IN_DATA_WIDTH > 1) ? $clog2(IN_DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(IN_DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                   state_q, state_d;
  logic [IN_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IN_DATA_WIDTH-1:0] pend_q, pend_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     ovr_q, ovr_d;
  logic                     load;
  logic [IN_DATA_WIDTH-1:0] load_word;
`ifdef ALU_SER_PARITY_EN
  logic                     par_q, par_d;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ovr_d        = 1'b0;
    load         = 1'b0;
    load_word    = ALU_OUT;
`ifdef ALU_SER_PARITY_EN
    par_d        = par_q;
`endif

    // Words arriving while a frame is on the line go to the one-entry buffer or are dropped.
    if (OUT_VALID && (state_q != StIdle)) begin
      if (pend_valid_q) begin
        ovr_d = 1'b1;
      end else begin
        pend_d       = ALU_OUT;
        pend_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (OUT_VALID) begin
          load      = 1'b1;
          load_word = ALU_OUT;
        end
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        if (cnt_q == LastBit) begin
`ifdef ALU_SER_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      StParity: state_d = StStop;
      StStop: begin
        // A word captured on this same edge is started directly so no idle gap appears.
        if (pend_valid_q) begin
          load         = 1'b1;
          load_word    = pend_q;
          pend_valid_d = 1'b0;
        end else if (OUT_VALID) begin
          load         = 1'b1;
          load_word    = ALU_OUT;
          pend_valid_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StStart;
      shift_d = load_word;
      cnt_d   = '0;
`ifdef ALU_SER_PARITY_EN
      par_d   = ^load_word;
`endif
    end
  end

  // Line outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef ALU_SER_PARITY_EN
      StParity: tx_d = par_q;
`else
      StParity: tx_d = 1'b1;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      ovr_q        <= 1'b0;
`ifdef ALU_SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
`ifdef ALU_SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign TX_OUT  = tx_q;
  assign TX_BUSY = busy_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_alu_out_serializer.sv
// Bench for alu_out_serializer: queue-based line model plus directed frame decoding.
module tb_alu_out_serializer;

  localparam int W = 16;
`ifdef ALU_SER_PARITY_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         OUT_VALID = 1'b0;
  logic [W-1:0] ALU_OUT = '0;
  logic         TX_OUT, TX_BUSY, OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cur holds the bits still to appear on the line, cur[0] being on it now.
  bit           cur[$];
  logic [W-1:0] pend[$];
  logic         exp_tx = 1'b1, exp_busy = 1'b0, exp_ovr = 1'b0;

  always #5 clk = ~clk;

  alu_out_serializer #(.IN_DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ALU_OUT  (ALU_OUT),
    .OUT_VALID(OUT_VALID),
    .TX_OUT   (TX_OUT),
    .TX_BUSY  (TX_BUSY),
    .OVERRUN  (OVERRUN)
  );

  task automatic load_frame(input logic [W-1:0] w);
    cur.delete();
    cur.push_back(1'b0);
    for (int i = 0; i < W; i++) cur.push_back(w[i]);
`ifdef ALU_SER_PARITY_EN
    cur.push_back(^w);
`endif
    cur.push_back(1'b1);
  endtask

  task automatic model_step();
    bit busy_now;
    exp_ovr = 1'b0;
    if (!rst) begin
      cur.delete();
      pend.delete();
    end else begin
      busy_now = (cur.size() != 0);
      if (busy_now) void'(cur.pop_front());
      if (OUT_VALID) begin
        if (!busy_now) load_frame(ALU_OUT);
        else if (pend.size() != 0) exp_ovr = 1'b1;
        else pend.push_back(ALU_OUT);
      end
      if (cur.size() == 0 && pend.size() != 0) load_frame(pend.pop_front());
    end
    exp_busy = (cur.size() != 0);
    exp_tx   = exp_busy ? cur[0] : 1'b1;
  endtask

  task automatic tick(input logic r, input logic v, input logic [W-1:0] w);
    @(negedge clk);
    rst = r; OUT_VALID = v; ALU_OUT = w;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 16'hFFFF);
    tick(1'b0, 1'b1, 16'h1234);
    n_checks++;
    if ({TX_OUT, TX_BUSY, OVERRUN} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_state: tx/busy/ovr=%b required 100", {TX_OUT, TX_BUSY, OVERRUN});
    end
    tick(1'b1, 1'b0, '0);
    n_checks++;
    if ({TX_OUT, TX_BUSY, OVERRUN} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release_idle: tx/busy/ovr=%b required 100", {TX_OUT, TX_BUSY, OVERRUN});
    end
  endtask

  task automatic test_single_word(input string tag, input logic [W-1:0] w);
    bit           got[$];
    logic [W-1:0] data;
    int           busy_cnt = 0;
    tick(1'b1, 1'b1, w);
    for (int c = 0; c < FL + 3; c++) begin
      n_checks++;
      if ({TX_OUT, TX_BUSY, OVERRUN} !== {exp_tx, exp_busy, exp_ovr}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: tx/busy/ovr=%b required %b", tag, c,
                 {TX_OUT, TX_BUSY, OVERRUN}, {exp_tx, exp_busy, exp_ovr});
      end
      if (TX_BUSY) begin
        busy_cnt++;
        got.push_back(TX_OUT);
      end
      tick(1'b1, 1'b0, W'($urandom));
    end
    n_checks++;
    if (busy_cnt != FL) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d cycles required %0d", tag, busy_cnt, FL);
    end else begin
      for (int i = 0; i < W; i++) data[i] = got[1 + i];
      n_checks++;
      if ({got[0], data, got[FL-1]} !== {1'b0, w, 1'b1}) begin
        n_fail++;
        $display("FAIL %s frame: start/data/stop=%b/%h/%b required 0/%h/1", tag,
                 got[0], data, got[FL-1], w);
      end
`ifdef ALU_SER_PARITY_EN
      n_checks++;
      if (got[W+1] !== ^w) begin
        n_fail++;
        $display("FAIL %s parity: got %b required %b", tag, got[W+1], ^w);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0;
    int drops    = 0;
    for (int c = 0; c < 2 * FL + 3; c++) begin
      if (c == 0)      tick(1'b1, 1'b1, 16'h1234);
      else if (c == 3) tick(1'b1, 1'b1, 16'hFFFF);
      else             tick(1'b1, 1'b0, W'($urandom));
      n_checks++;
      if ({TX_OUT, TX_BUSY, OVERRUN} !== {exp_tx, exp_busy, exp_ovr}) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: tx/busy/ovr=%b required %b", c,
                 {TX_OUT, TX_BUSY, OVERRUN}, {exp_tx, exp_busy, exp_ovr});
      end
      if (TX_BUSY) busy_cnt++;
      if (c < 2 * FL && !TX_BUSY) drops++;
    end
    n_checks++;
    if (drops != 0 || busy_cnt != 2 * FL) begin
      n_fail++;
      $display("FAIL back_to_back_busy: drops=%0d busy=%0d required drops=0 busy=%0d",
               drops, busy_cnt, 2 * FL);
    end
  endtask

  task automatic test_overrun();
    int ovr_cnt = 0;
    int ovr_at  = -1;
    for (int c = 0; c < 2 * FL + 4; c++) begin
      tick(1'b1, (c < 3), W'($urandom));
      n_checks++;
      if ({TX_OUT, TX_BUSY, OVERRUN} !== {exp_tx, exp_busy, exp_ovr}) begin
        n_fail++;
        $display("FAIL overrun cycle %0d: tx/busy/ovr=%b required %b", c,
                 {TX_OUT, TX_BUSY, OVERRUN}, {exp_tx, exp_busy, exp_ovr});
      end
      if (OVERRUN) begin
        ovr_cnt++;
        ovr_at = c;
      end
    end
    n_checks++;
    if (ovr_cnt != 1 || ovr_at != 2) begin
      n_fail++;
      $display("FAIL overrun_pulse: count=%0d at=%0d required count=1 at=2", ovr_cnt, ovr_at);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    w = W'($urandom);
    tick(1'b1, 1'b1, w);
    for (int c = 0; c < 6; c++) tick(1'b1, 1'b0, W'($urandom));
    n_checks++;
    if ({TX_OUT, TX_BUSY} !== {w[5], 1'b1}) begin
      n_fail++;
      $display("FAIL mid_frame_bit5: tx/busy=%b required %b", {TX_OUT, TX_BUSY}, {w[5], 1'b1});
    end
    tick(1'b0, 1'b1, W'($urandom));
    n_checks++;
    if ({TX_OUT, TX_BUSY, OVERRUN} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_frame_reset: tx/busy/ovr=%b required 100", {TX_OUT, TX_BUSY, OVERRUN});
    end
    tick(1'b1, 1'b0, '0);
    n_checks++;
    if ({TX_OUT, TX_BUSY} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_idle: tx/busy=%b required 10", {TX_OUT, TX_BUSY});
    end
    test_single_word("after_reset", 16'h00FF);
  endtask

  task automatic test_boundary();
    tick(1'b1, 1'b1, W'($urandom));
    for (int c = 1; c < FL; c++) tick(1'b1, 1'b0, W'($urandom));
    n_checks++;
    if ({TX_OUT, TX_BUSY, exp_tx} !== 3'b111) begin
      n_fail++;
      $display("FAIL boundary_stop: tx/busy=%b required 11", {TX_OUT, TX_BUSY});
    end
    tick(1'b1, 1'b1, 16'h8000);
    n_checks++;
    if ({TX_OUT, TX_BUSY} !== 2'b01) begin
      n_fail++;
      $display("FAIL boundary_start: tx/busy=%b required 01", {TX_OUT, TX_BUSY});
    end
    for (int c = 0; c < W; c++) tick(1'b1, 1'b0, W'($urandom));
    n_checks++;
    if ({TX_OUT, TX_BUSY} !== 2'b11) begin
      n_fail++;
      $display("FAIL boundary_last_bit: tx/busy=%b required 11", {TX_OUT, TX_BUSY});
    end
    for (int c = 0; c < FL; c++) begin
      tick(1'b1, 1'b0, W'($urandom));
      n_checks++;
      if ({TX_OUT, TX_BUSY, OVERRUN} !== {exp_tx, exp_busy, exp_ovr}) begin
        n_fail++;
        $display("FAIL boundary_drain cycle %0d: tx/busy/ovr=%b required %b", c,
                 {TX_OUT, TX_BUSY, OVERRUN}, {exp_tx, exp_busy, exp_ovr});
      end
    end
  endtask

  task automatic test_random();
    logic r, v;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) == 0);
      tick(r, v, W'($urandom));
      n_checks++;
      if ({TX_OUT, TX_BUSY, OVERRUN} !== {exp_tx, exp_busy, exp_ovr}) begin
        n_fail++;
        $display("FAIL random cycle %0d: tx/busy/ovr=%b required %b", c,
                 {TX_OUT, TX_BUSY, OVERRUN}, {exp_tx, exp_busy, exp_ovr});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word("word_a5c3", 16'hA5C3);
    test_single_word("word_0001", 16'h0001);
    test_back_to_back();
    for (int c = 0; c < FL; c++) tick(1'b1, 1'b0, '0);
    test_overrun();
    for (int c = 0; c < FL; c++) tick(1'b1, 1'b0, '0);
    test_reset_mid_frame();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
